// File: rtl/fb_pkg.sv
// Shared types and storage geometry for the double-buffered frame store.
package fb_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} fb_state_t;
  typedef logic [2:0] color3_t;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = 19200;
  localparam int FB_AW    = 15;

endpackage

// File: rtl/fb_ram.sv
// One 3-bit pixel plane: single write port, registered read port.
module fb_ram
  import fb_pkg::*;
(
  input  logic             clk,
  input  logic             i_we,
  input  logic [FB_AW-1:0] i_waddr,
  input  color3_t          i_wdata,
  input  logic [FB_AW-1:0] i_raddr,
  output color3_t          o_rdata
);

  color3_t r_mem [FB_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered reduced-resolution frame store: game writes the back plane,
// video reads the front plane, planes swap only at end of an active frame.
module frame_buffer
  import fb_pkg::*;
#(
  parameter int      WIDTH      = 640,
  parameter int      HEIGHT     = 480,
  parameter int      SCALE_LOG2 = 2,
  parameter color3_t BG_COLOR   = 3'b000
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [9:0] wr_x,
  input  logic [8:0] wr_y,
  input  logic [2:0] wr_color,
  input  logic       clear_req,
  input  logic       swap_req,
  input  logic [9:0] x,
  input  logic [8:0] y,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       front_sel,
  output logic       busy,
  output logic       swap_done
);

  localparam logic [9:0]       X_LIM     = 10'(WIDTH);
  localparam logic [8:0]       Y_LIM     = 9'(HEIGHT);
  localparam logic [9:0]       X_LAST    = 10'(WIDTH - 1);
  localparam logic [8:0]       Y_LAST    = 9'(HEIGHT - 1);
  localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(FB_DEPTH - 1);

  // Row stride of 160 built from shifts: 160 = 128 + 32.
  function automatic logic [FB_AW-1:0] pix_addr(input logic [9:0] px, input logic [8:0] py);
    logic [FB_AW-1:0] cx;
    logic [FB_AW-1:0] cy;
    cx = FB_AW'(px >> SCALE_LOG2);
    cy = FB_AW'(py >> SCALE_LOG2);
    return (cy << 7) + (cy << 5) + cx;
  endfunction

  fb_state_t        r_state;
  fb_state_t        w_state_nxt;
  logic [FB_AW-1:0] r_cnt;
  logic             r_front_sel;
  logic             r_swap_done;
  logic             r_rd_vld;
  logic             r_rd_sel;

  logic             w_last_pix;
  logic             w_wr_in_range;
  logic             w_rd_in_range;
  logic [FB_AW-1:0] w_wr_addr;
  logic [FB_AW-1:0] w_rd_addr;
  logic             w_we;
  logic [FB_AW-1:0] w_waddr;
  color3_t          w_wdata;
  color3_t          w_rd0;
  color3_t          w_rd1;
  color3_t          w_pix;

  assign w_last_pix    = (x == X_LAST) && (y == Y_LAST);
  assign w_wr_in_range = (wr_x < X_LIM) && (wr_y < Y_LIM);
  assign w_rd_in_range = (x < X_LIM) && (y < Y_LIM);
  assign w_wr_addr     = pix_addr(wr_x, wr_y);
  assign w_rd_addr     = w_rd_in_range ? pix_addr(x, y) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (clear_req)     w_state_nxt = CLEAR;
        else if (swap_req) w_state_nxt = SWAP_WAIT;
      end
      CLEAR:     if (r_cnt == LAST_ADDR) w_state_nxt = IDLE;
      SWAP_WAIT: if (w_last_pix)         w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_ready = 1'b0;
    busy     = 1'b0;
    w_we     = 1'b0;
    w_waddr  = w_wr_addr;
    w_wdata  = wr_color;
    case (r_state)
      IDLE: begin
        wr_ready = 1'b1;
        w_we     = wr_valid & w_wr_in_range;
      end
      CLEAR: begin
        busy    = 1'b1;
        w_we    = 1'b1;
        w_waddr = r_cnt;
        w_wdata = BG_COLOR;
      end
      SWAP_WAIT: busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_front_sel <= 1'b0;
      r_swap_done <= 1'b0;
    end else begin
      if (r_state == IDLE && clear_req) r_cnt <= '0;
      else if (r_state == CLEAR)        r_cnt <= r_cnt + FB_AW'(1);
      r_swap_done <= (r_state == SWAP_WAIT) && w_last_pix;
      if ((r_state == SWAP_WAIT) && w_last_pix) r_front_sel <= ~r_front_sel;
    end
  end

  // Remember which plane and range applied to the pixel now leaving the RAMs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_vld <= 1'b0;
      r_rd_sel <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_in_range;
      r_rd_sel <= r_front_sel;
    end
  end

  fb_ram u_ram0 (
    .clk    (clk),
    .i_we   (w_we & r_front_sel),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_raddr(w_rd_addr),
    .o_rdata(w_rd0)
  );

  fb_ram u_ram1 (
    .clk    (clk),
    .i_we   (w_we & ~r_front_sel),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_raddr(w_rd_addr),
    .o_rdata(w_rd1)
  );

  assign w_pix     = r_rd_sel ? w_rd1 : w_rd0;
  assign r         = {8{r_rd_vld & w_pix[2]}};
  assign g         = {8{r_rd_vld & w_pix[1]}};
  assign b         = {8{r_rd_vld & w_pix[0]}};
  assign front_sel = r_front_sel;
  assign swap_done = r_swap_done;

endmodule

// File: tb/tb_frame_buffer.sv
// Bench for frame_buffer: per-cycle comparison against a plane/array model plus directed literal checks.
module tb_frame_buffer;

  localparam int FBD = 19200;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [9:0] wr_x = '0;
  logic [8:0] wr_y = '0;
  logic [2:0] wr_color = '0;
  logic       clear_req = 1'b0;
  logic       swap_req = 1'b0;
  logic [9:0] x = '0;
  logic [8:0] y = '0;
  logic [7:0] r, g, b;
  logic       front_sel, busy, swap_done;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  frame_buffer dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .clear_req(clear_req),
    .swap_req(swap_req), .x(x), .y(y), .r(r), .g(g), .b(b),
    .front_sel(front_sel), .busy(busy), .swap_done(swap_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: two pixel planes indexed by block address, plus what the display side must show.
  logic [2:0] mb [2][FBD];
  bit         kn [2][FBD];
  int         m_front;
  int         m_clear_left;
  bit         m_pending;
  bit         m_swap_done;
  logic [2:0] m_rgb;
  bit         m_rgb_kn;

  function automatic int faddr(input int px, input int py);
    return (py / 4) * 160 + px / 4;
  endfunction

  task automatic model_reset();
    m_front = 0; m_clear_left = 0; m_pending = 0; m_swap_done = 0;
    m_rgb = 3'b000; m_rgb_kn = 1;
  endtask

  task automatic model_step();
    int a;
    int bk;
    bk = 1 - m_front;
    if (int'(x) < 640 && int'(y) < 480) begin
      a = faddr(int'(x), int'(y));
      m_rgb = mb[m_front][a];
      m_rgb_kn = kn[m_front][a];
    end else begin
      m_rgb = 3'b000;
      m_rgb_kn = 1;
    end
    m_swap_done = 0;
    if (m_clear_left == 0 && !m_pending) begin
      if (wr_valid && int'(wr_x) < 640 && int'(wr_y) < 480) begin
        a = faddr(int'(wr_x), int'(wr_y));
        mb[bk][a] = wr_color;
        kn[bk][a] = 1;
      end
      if (clear_req)     m_clear_left = FBD;
      else if (swap_req) m_pending = 1;
    end else if (m_clear_left > 0) begin
      a = FBD - m_clear_left;
      mb[bk][a] = 3'b000;
      kn[bk][a] = 1;
      m_clear_left--;
    end else if (int'(x) == 639 && int'(y) == 479) begin
      m_front = bk;
      m_pending = 0;
      m_swap_done = 1;
    end
  endtask

  always @(posedge reset) model_reset();

  always @(posedge clk) begin
    if (chk_en && !reset) model_step();
    #1;
    if (chk_en) begin
      check("cmp_front_sel", 32'(front_sel), 32'(m_front));
      check("cmp_busy", 32'(busy), 32'(m_clear_left > 0 || m_pending));
      check("cmp_wr_ready", 32'(wr_ready), 32'(!(m_clear_left > 0 || m_pending)));
      check("cmp_swap_done", 32'(swap_done), 32'(m_swap_done));
      if (m_rgb_kn) begin
        check("cmp_r", 32'(r), m_rgb[2] ? 32'd255 : 32'd0);
        check("cmp_g", 32'(g), m_rgb[1] ? 32'd255 : 32'd0);
        check("cmp_b", 32'(b), m_rgb[0] ? 32'd255 : 32'd0);
      end
    end
  end

  task automatic do_clear(input bit both, input bit sweep, output bit saw_sd);
    int n;
    @(negedge clk); clear_req = 1'b1; swap_req = both;
    @(negedge clk); clear_req = 1'b0; swap_req = 1'b0;
    n = 0;
    saw_sd = 0;
    for (int k = 0; k < 20000; k++) begin
      if (!busy) break;
      n++;
      if (swap_done) saw_sd = 1;
      if (sweep) begin
        x = 10'((k * 7) % 700);
        y = 9'((k * 13) % 512);
      end
      @(negedge clk);
    end
    x = '0; y = '0;
    check("clear_cycles", 32'(n), 32'd19200);
    check("clear_ready_after", 32'(wr_ready), 32'd1);
  endtask

  task automatic do_swap(input bit exp_front);
    @(negedge clk); swap_req = 1'b1;
    @(negedge clk); swap_req = 1'b0;
    check("swap_wait_busy", 32'(busy), 32'd1);
    x = 10'd639; y = 9'd479;
    @(negedge clk);
    check("swap_front_sel", 32'(front_sel), 32'(exp_front));
    check("swap_done_pulse", 32'(swap_done), 32'd1);
    x = '0; y = '0;
    @(negedge clk);
    check("swap_done_single", 32'(swap_done), 32'd0);
  endtask

  task automatic do_write(input int px, input int py, input logic [2:0] c);
    @(negedge clk);
    wr_valid = 1'b1; wr_x = 10'(px); wr_y = 9'(py); wr_color = c;
    check("wr_handshake", 32'(wr_ready), 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic present(input string name, input int px, input int py, input logic [23:0] exp);
    @(negedge clk); x = 10'(px); y = 9'(py);
    @(negedge clk);
    check(name, 32'({r, g, b}), 32'(exp));
  endtask

  initial begin
    bit sd;
    #3 reset = 1'b1;
    chk_en = 1'b1;
    #1;
    check("rst_rgb", 32'({r, g, b}), 32'd0);
    check("rst_front_sel", 32'(front_sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_swap_done", 32'(swap_done), 32'd0);
    @(negedge clk); @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);

    // Clear both planes so every later read is fully predictable.
    do_clear(1'b0, 1'b0, sd);
    do_swap(1'b1);
    do_clear(1'b0, 1'b1, sd);

    do_write(8, 4, 3'b100);
    do_write(640, 0, 3'b111);
    do_write(100, 100, 3'b011);
    do_swap(1'b0);
    present("read_red", 9, 5, 24'hFF0000);
    present("read_black_neighbour", 12, 4, 24'h000000);
    for (int i = 636; i < 640; i++) present("oor_write_dropped", i, 0, 24'h000000);
    present("read_cyan", 101, 103, 24'h00FFFF);
    present("read_x_oor", 640, 5, 24'h000000);

    do_clear(1'b1, 1'b0, sd);
    check("simul_front_kept", 32'(front_sel), 32'd0);
    check("simul_no_swap_done", 32'(sd), 32'd0);
    present("simul_no_swap_red", 9, 5, 24'hFF0000);

    do_write(0, 0, 3'b111);
    do_swap(1'b1);
    present("read_white", 0, 0, 24'hFFFFFF);

    @(negedge clk); clear_req = 1'b1;
    @(negedge clk); clear_req = 1'b0;
    repeat (99) @(negedge clk);
    check("midclear_busy", 32'(busy), 32'd1);
    check("midclear_rgb_white", 32'({r, g, b}), 32'hFFFFFF);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rgb", 32'({r, g, b}), 32'd0);
    check("midrst_front_sel", 32'(front_sel), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("midrst_wr_ready", 32'(wr_ready), 32'd1);
    do_clear(1'b0, 1'b0, sd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
